// File: rtl/uart_mon_pkg.sv
// Shared types and helpers for the UART receive monitor.
package uart_mon_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Expected parity bit for a zero-extended character.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_mon_fifo.sv
// Synchronous FIFO with pop-before-push semantics when full.
module uart_mon_fifo
  import uart_mon_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head,
  output logic                          full,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_fire;
  logic             push_fire;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign pop_fire  = pop && !empty;
  assign push_fire = push && (!full || pop_fire);
  assign head      = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + AW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_fire) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: synchroniser, prescaler, frame FSM, error flags,
// character matcher and receive FIFO.
module uart_rx_monitor
  import uart_mon_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                               HCLK,
  input  logic                               HRESET,
  input  logic                               en,
  input  logic                               rx,
  input  logic [15:0]                        baud_div,
  input  logic                               parity_en,
  input  logic                               parity_odd,
  input  logic                               stop2,
  input  logic [DATA_BITS-1:0]               match_char,
  input  logic                               rd_ready,
  output logic                               rd_valid,
  output logic [DATA_BITS-1:0]               rd_data,
  output logic [count_width(FIFO_DEPTH)-1:0] fifo_count,
  output logic                               match_hit,
  output logic                               frame_err,
  output logic                               parity_err,
  output logic                               overflow,
  input  logic                               err_clr
);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_params
      $error("uart_rx_monitor: illegal DATA_BITS, FIFO_DEPTH or OVERSAMPLE");
    end
  endgenerate

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] MID  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] LAST = OSW'(OVERSAMPLE - 1);

  logic                 rx_meta, rxs, rxs_d;
  state_t               state;
  logic [15:0]          presc, div_q;
  logic [OSW-1:0]       os_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad, stop_bad;
  logic                 push, set_frame, set_par;
  logic [DATA_BITS-1:0] push_data;
  logic                 tick, mid, bit_end, frame_done, stop_ok;
  logic                 fifo_full, fifo_empty;

  assign tick       = (state != IDLE) && (presc == div_q);
  assign mid        = tick && (os_cnt == MID);
  assign bit_end    = tick && (os_cnt == LAST);
  assign frame_done = mid && ((state == STOP1 && !stop2) || state == STOP2);
  assign stop_ok    = !stop_bad && rxs;
  assign rd_valid   = !fifo_empty;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  // A new divisor is only picked up when the prescaler wraps or sits idle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      presc <= '0;
      div_q <= '0;
    end else if (!en || state == IDLE || presc == div_q) begin
      presc <= '0;
      div_q <= baud_div;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bad   <= 1'b0;
      stop_bad  <= 1'b0;
      push      <= 1'b0;
      push_data <= '0;
      set_frame <= 1'b0;
      set_par   <= 1'b0;
      match_hit <= 1'b0;
    end else begin
      push      <= 1'b0;
      set_frame <= 1'b0;
      set_par   <= 1'b0;
      match_hit <= 1'b0;
      if (!en) begin
        state  <= IDLE;
        os_cnt <= '0;
      end else begin
        if (tick) os_cnt <= (os_cnt == LAST) ? '0 : os_cnt + OSW'(1);
        case (state)
          IDLE: begin
            os_cnt   <= '0;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            if (rxs_d && !rxs) state <= START;
          end
          START: begin
            if (mid && rxs)   state <= IDLE;
            else if (bit_end) state <= DATA;
          end
          DATA: begin
            if (mid) begin
              shreg   <= {rxs, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (bit_end && bit_cnt == 4'(DATA_BITS))
              state <= parity_en ? PARITY : STOP1;
          end
          PARITY: begin
            if (mid)     par_bad <= (rxs != parity_bit(9'(shreg), parity_odd));
            if (bit_end) state   <= STOP1;
          end
          STOP1: begin
            if (mid && stop2)     stop_bad <= !rxs;
            if (bit_end && stop2) state    <= STOP2;
          end
          STOP2: ;
          default: state <= IDLE;
        endcase
        // Finishing at mid-stop leaves half a bit to catch a back-to-back start.
        if (frame_done) begin
          state     <= IDLE;
          push      <= stop_ok;
          push_data <= shreg;
          set_frame <= !stop_ok;
          set_par   <= stop_ok && par_bad;
          match_hit <= stop_ok && (shreg == match_char);
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err  <= set_frame | (frame_err & ~err_clr);
      parity_err <= set_par | (parity_err & ~err_clr);
      overflow   <= (push && fifo_full && !(rd_ready && rd_valid)) | (overflow & ~err_clr);
    end
  end

  uart_mon_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (HCLK),
    .reset    (HRESET),
    .push     (push),
    .push_data(push_data),
    .pop      (rd_ready),
    .head     (rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench: an 8-bit depth-4 monitor for the main tests and a
// 7O2 monitor for the mid-frame reset test.
module tb_uart_rx_monitor;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  logic        en, rx_a, rx_b;
  logic [15:0] baud_div_a;
  logic        parity_en_a, parity_odd_a, stop2_a;
  logic [7:0]  match_char_a;
  logic        rd_ready_a, err_clr_a;
  logic        rd_valid_a, match_hit_a, frame_err_a, parity_err_a, overflow_a;
  logic [7:0]  rd_data_a;
  logic [2:0]  fifo_count_a;

  logic        rd_valid_b, match_hit_b, frame_err_b, parity_err_b, overflow_b;
  logic [6:0]  rd_data_b;
  logic [4:0]  fifo_count_b;

  int checks_total  = 0;
  int checks_passed = 0;
  int mh_cycles     = 0;
  int mh_cnt_at     = -1;
  int mh_cnt_after  = -1;
  logic mh_prev     = 1'b0;

  uart_rx_monitor #(.DATA_BITS(8), .FIFO_DEPTH(4), .OVERSAMPLE(16)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .en(en), .rx(rx_a), .baud_div(baud_div_a),
    .parity_en(parity_en_a), .parity_odd(parity_odd_a), .stop2(stop2_a),
    .match_char(match_char_a), .rd_ready(rd_ready_a), .rd_valid(rd_valid_a),
    .rd_data(rd_data_a), .fifo_count(fifo_count_a), .match_hit(match_hit_a),
    .frame_err(frame_err_a), .parity_err(parity_err_a), .overflow(overflow_a),
    .err_clr(err_clr_a)
  );

  uart_rx_monitor #(.DATA_BITS(7), .FIFO_DEPTH(16), .OVERSAMPLE(16)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .en(en), .rx(rx_b), .baud_div(16'd3),
    .parity_en(1'b1), .parity_odd(1'b1), .stop2(1'b1),
    .match_char(7'h7F), .rd_ready(1'b0), .rd_valid(rd_valid_b),
    .rd_data(rd_data_b), .fifo_count(fifo_count_b), .match_hit(match_hit_b),
    .frame_err(frame_err_b), .parity_err(parity_err_b), .overflow(overflow_b),
    .err_clr(1'b0)
  );

  // Records how long match_hit stays high and the occupancy around it.
  always @(negedge HCLK) begin
    if (mh_prev) mh_cnt_after = int'(fifo_count_a);
    mh_prev = match_hit_a;
    if (match_hit_a) begin
      mh_cycles = mh_cycles + 1;
      mh_cnt_at = int'(fifo_count_a);
    end
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_frame(input bit to_b, input logic [8:0] d, input int nbits,
                            input int bitcyc, input bit pen, input bit podd,
                            input bit pflip, input int nstop, input bit stop_low);
    logic bits [16];
    int n;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nbits; i++) begin
      bits[n] = d[i];
      n++;
    end
    if (pen) begin
      bits[n] = (^d) ^ podd ^ pflip;
      n++;
    end
    for (int s = 0; s < nstop; s++) begin
      bits[n] = !stop_low;
      n++;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK); #1;
      if (to_b) rx_b = bits[i];
      else      rx_a = bits[i];
      repeat (bitcyc - 1) @(posedge HCLK);
    end
    if (stop_low) begin
      @(posedge HCLK); #1;
      if (to_b) rx_b = 1'b1;
      else      rx_a = 1'b1;
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    send_frame(1'b0, {1'b0, d}, 8, 16, 1'b0, 1'b0, 1'b0, 1, 1'b0);
  endtask

  task automatic pop_a();
    @(posedge HCLK); #1 rd_ready_a = 1'b1;
    @(posedge HCLK); #1 rd_ready_a = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic pulse_clr_a();
    @(posedge HCLK); #1 err_clr_a = 1'b1;
    @(posedge HCLK); #1 err_clr_a = 1'b0;
    @(negedge HCLK);
  endtask

  initial begin
    HRESET = 1'b1; en = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    baud_div_a = 16'd0; parity_en_a = 1'b0; parity_odd_a = 1'b0; stop2_a = 1'b0;
    match_char_a = 8'hFF; rd_ready_a = 1'b0; err_clr_a = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);

    $display("[TB] reset state");
    check_output("rst_rd_valid",   rd_valid_a,   1'b0);
    check_output("rst_rd_data",    rd_data_a,    8'h00);
    check_output("rst_count",      fifo_count_a, 3'd0);
    check_output("rst_match_hit",  match_hit_a,  1'b0);
    check_output("rst_frame_err",  frame_err_a,  1'b0);
    check_output("rst_parity_err", parity_err_a, 1'b0);
    check_output("rst_overflow",   overflow_a,   1'b0);
    check_output("rst_b_count",    fifo_count_b, 5'd0);
    repeat (5) @(posedge HCLK);

    $display("[TB] 8N1 back-to-back 0x55 0xA3");
    send_a(8'h55);
    send_a(8'hA3);
    @(negedge HCLK);
    check_output("b2b_count",    fifo_count_a, 3'd2);
    check_output("b2b_first",    rd_data_a,    8'h55);
    check_output("b2b_flags",    {frame_err_a, parity_err_a, overflow_a}, 3'b000);
    pop_a();
    check_output("b2b_second",   rd_data_a,    8'hA3);
    pop_a();
    check_output("b2b_empty",    fifo_count_a, 3'd0);
    check_output("b2b_rd_valid", rd_valid_a,   1'b0);

    $display("[TB] 8E1 bad parity 0x07");
    parity_en_a = 1'b1;
    send_frame(1'b0, 9'h007, 8, 16, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    @(negedge HCLK);
    check_output("par_count",      fifo_count_a, 3'd1);
    check_output("par_data",       rd_data_a,    8'h07);
    check_output("par_parity_err", parity_err_a, 1'b1);
    check_output("par_frame_err",  frame_err_a,  1'b0);
    pulse_clr_a();
    check_output("par_cleared",    parity_err_a, 1'b0);
    pop_a();
    parity_en_a = 1'b0;

    $display("[TB] framing error then start glitch");
    send_frame(1'b0, 9'h041, 8, 16, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    repeat (20) @(posedge HCLK);
    @(posedge HCLK); #1 rx_a = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 rx_a = 1'b1;
    repeat (40) @(posedge HCLK);
    @(negedge HCLK);
    check_output("frm_frame_err",  frame_err_a,  1'b1);
    check_output("frm_count",      fifo_count_a, 3'd0);
    check_output("frm_parity_err", parity_err_a, 1'b0);
    pulse_clr_a();
    check_output("frm_cleared",    frame_err_a,  1'b0);

    $display("[TB] match on newline");
    match_char_a = 8'h0A;
    send_a(8'h4F);
    send_a(8'h4B);
    send_a(8'h0A);
    @(negedge HCLK);
    check_output("mch_count",      fifo_count_a,       3'd3);
    check_output("mch_cycles",     16'(mh_cycles),     16'd1);
    check_output("mch_count_at",   16'(mh_cnt_at),     16'd2);
    check_output("mch_count_next", 16'(mh_cnt_after),  16'd3);
    check_output("mch_head_O",     rd_data_a,          8'h4F);
    pop_a();
    check_output("mch_head_K",     rd_data_a,          8'h4B);
    pop_a();
    check_output("mch_head_nl",    rd_data_a,          8'h0A);
    pop_a();

    $display("[TB] overflow on depth-4 FIFO");
    send_a(8'h11);
    send_a(8'h22);
    send_a(8'h33);
    send_a(8'h44);
    send_a(8'h66);
    @(negedge HCLK);
    check_output("ovf_count", fifo_count_a, 3'd4);
    check_output("ovf_flag",  overflow_a,   1'b1);
    check_output("ovf_head",  rd_data_a,    8'h11);
    pulse_clr_a();
    check_output("ovf_cleared", overflow_a, 1'b0);
    fork
      send_a(8'h77);
      begin
        repeat (155) @(posedge HCLK);
        pop_a();
      end
    join
    @(negedge HCLK);
    check_output("pp_count",    fifo_count_a, 3'd4);
    check_output("pp_overflow", overflow_a,   1'b0);
    check_output("pp_head0",    rd_data_a,    8'h22);
    pop_a();
    check_output("pp_head1",    rd_data_a,    8'h33);
    pop_a();
    check_output("pp_head2",    rd_data_a,    8'h44);
    pop_a();
    check_output("pp_head3",    rd_data_a,    8'h77);
    pop_a();
    check_output("pp_empty",    fifo_count_a, 3'd0);

    $display("[TB] 7O2 reset mid-frame then resend");
    @(posedge HCLK); #1 rx_b = 1'b0;
    repeat (100) @(posedge HCLK);
    #1 HRESET = 1'b1; rx_b = 1'b1;
    @(posedge HCLK); #1 HRESET = 1'b0;
    repeat (50) @(posedge HCLK);
    @(negedge HCLK);
    check_output("b_rst_count", fifo_count_b, 5'd0);
    check_output("b_rst_valid", rd_valid_b,   1'b0);
    send_frame(1'b1, 9'h05A, 7, 64, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    @(negedge HCLK);
    check_output("b_count",      fifo_count_b, 5'd1);
    check_output("b_data",       rd_data_b,    7'h5A);
    check_output("b_parity_err", parity_err_b, 1'b0);
    check_output("b_frame_err",  frame_err_b,  1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
